// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path:
// FSM states, opcodes, ALU and immediate-extender selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
        logic       retire;
    } ctrl_t;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE: return IMM_S;
            OP_BEQ:   return IMM_B;
            OP_JAL:   return IMM_J;
            default:  return IMM_I;
        endcase
    endfunction

    function automatic logic op_supported(input logic [6:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_RTYPE,
                          OP_ITYPE, OP_BEQ, OP_JAL};
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's coarse alu_op plus instruction
// function bits onto the ALU operation select.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // only R-type has a sub; addi reuses funct7 bits as imm
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences the
// shared datapath and handshakes with the cache on mem_ready.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       imm_src,
    output logic [2:0]       alu_control,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q;
    state_t           state_d;
    ctrl_t            ctrl;
    logic [2:0]       alu_ctrl;
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (ctrl.retire)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BEQ:            state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        unique case (state_q)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_update  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b01;
                ctrl.illegal   = ~op_supported(op);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = 2'b01;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.adr_src   = 1'b1;
                ctrl.retire    = mem_ready;
            end
            S_EXECR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_op    = ALU_OP_SUB;
                ctrl.branch    = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b10;
                ctrl.pc_update = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (ctrl.alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_ctrl)
    );

    // reset silences every output, including a pending cache request
    assign mem_req     = ~reset & ctrl.mem_req;
    assign mem_write   = ~reset & ctrl.mem_write;
    assign adr_src     = ~reset & ctrl.adr_src;
    assign ir_write    = ~reset & ctrl.ir_write;
    assign pc_write    = ~reset & (ctrl.pc_update | (ctrl.branch & zero));
    assign reg_write   = ~reset & ctrl.reg_write;
    assign result_src  = reset ? 2'b00 : ctrl.result_src;
    assign alu_src_a   = reset ? 2'b00 : ctrl.alu_src_a;
    assign alu_src_b   = reset ? 2'b00 : ctrl.alu_src_b;
    assign imm_src     = reset ? 2'b00 : imm_src_of(op);
    assign alu_control = reset ? 3'b000 : alu_ctrl;
    assign illegal     = ~reset & ctrl.illegal;
    assign retired     = reset ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed table,
// hand-written corner sequences and randomized instruction stream.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write;
    logic        reg_write, illegal;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic [31:0] retired;

    logic        w_mem_req, w_mem_write, w_adr_src, w_ir_write;
    logic        w_pc_write, w_reg_write, w_illegal;
    logic [1:0]  w_result_src, w_alu_src_a, w_alu_src_b, w_imm_src;
    logic [2:0]  w_alu_control;
    logic [1:0]  w_retired;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .illegal(illegal), .retired(retired)
    );

    // narrow counter copy exercises the wrap-around
    multicycle_controller #(.CNT_W(2)) dut_w (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .mem_req(w_mem_req), .mem_write(w_mem_write), .adr_src(w_adr_src),
        .ir_write(w_ir_write), .pc_write(w_pc_write),
        .reg_write(w_reg_write), .result_src(w_result_src),
        .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
        .imm_src(w_imm_src), .alu_control(w_alu_control),
        .illegal(w_illegal), .retired(w_retired)
    );

    typedef struct {
        logic       mem_req, mem_write, adr_src, ir_write;
        logic       pc_write, reg_write, illegal;
        logic [1:0] result_src, a, b, imm;
        logic [2:0] alu;
    } snap_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z;
        int         fw, dw;
        int         cyc, pcw, regw, memw, ill;
        logic [1:0] a3, b3, rs_wb, imm;
        logic [2:0] alu3;
    } vec_t;

    int          compared = 0;
    int          mismatched = 0;
    int          wait_cnt = 0;
    logic [31:0] exp_retired = 0;
    logic [6:0]  v_op = 0;
    logic [2:0]  v_f3 = 0;
    logic        v_f7 = 0, v_z = 0;
    vec_t        tbl[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clock: drive inputs, let the cache model answer, sample outputs
    task automatic cyc(input int fw, input int dw, output snap_t s);
        @(negedge clk);
        op = v_op; funct3 = v_f3; funct7b5 = v_f7; zero = v_z;
        #0;
        if (mem_req)
            mem_ready = (wait_cnt >= (adr_src ? dw : fw));
        else
            mem_ready = 1'($urandom_range(0, 1));
        #1;
        s.mem_req = mem_req;     s.mem_write = mem_write;
        s.adr_src = adr_src;     s.ir_write = ir_write;
        s.pc_write = pc_write;   s.reg_write = reg_write;
        s.illegal = illegal;     s.result_src = result_src;
        s.a = alu_src_a;         s.b = alu_src_b;
        s.imm = imm_src;         s.alu = alu_control;
        if (mem_req) wait_cnt = mem_ready ? 0 : wait_cnt + 1;
    endtask

    function automatic vec_t mk(input string name, input logic [6:0] o,
        input logic [2:0] f3, input logic f7, input logic z,
        input int cyc_n, input int pcw, input int regw, input int memw,
        input int ill, input logic [1:0] a3, input logic [1:0] b3,
        input logic [1:0] rs_wb, input logic [1:0] imm,
        input logic [2:0] alu3);
        vec_t v;
        v.name = name; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z;
        v.fw = 0; v.dw = 0; v.cyc = cyc_n; v.pcw = pcw; v.regw = regw;
        v.memw = memw; v.ill = ill; v.a3 = a3; v.b3 = b3;
        v.rs_wb = rs_wb; v.imm = imm; v.alu3 = alu3;
        return v;
    endfunction

    // reference: instruction class rules, not the controller's states
    function automatic vec_t model(input logic [6:0] o, input logic [2:0] f3,
        input logic f7, input logic z, input int fw, input int dw);
        vec_t v;
        v = mk("rand", o, f3, f7, z, fw + 2, 1, 0, 0, 0,
               2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        v.fw = fw; v.dw = dw;
        case (o)
            7'b0000011: begin
                v.cyc += dw + 3; v.regw = 1; v.rs_wb = 2'b01;
                v.a3 = 2'b10; v.b3 = 2'b01;
            end
            7'b0100011: begin
                v.cyc += dw + 2; v.memw = dw + 1; v.imm = 2'b01;
                v.a3 = 2'b10; v.b3 = 2'b01;
            end
            7'b0110011, 7'b0010011: begin
                v.cyc += 2; v.regw = 1; v.a3 = 2'b10;
                v.b3 = (o == 7'b0110011) ? 2'b00 : 2'b01;
                case (f3)
                    3'b000: v.alu3 = (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
                    3'b010: v.alu3 = 3'b101;
                    3'b110: v.alu3 = 3'b011;
                    3'b111: v.alu3 = 3'b010;
                    default: v.alu3 = 3'b000;
                endcase
            end
            7'b1100011: begin
                v.cyc += 1; v.pcw = z ? 2 : 1; v.imm = 2'b10;
                v.a3 = 2'b10; v.alu3 = 3'b001;
            end
            7'b1101111: begin
                v.cyc += 2; v.pcw = 2; v.regw = 1; v.imm = 2'b11;
                v.a3 = 2'b01; v.b3 = 2'b10;
            end
            default: v.ill = 1;
        endcase
        return v;
    endfunction

    task automatic run_instr(input vec_t v);
        snap_t s;
        int fetch_n = 0, ir_n = 0, pcw_n = 0, regw_n = 0;
        int memw_n = 0, ill_n = 0, bad_imm = 0, bad_wb = 0;
        v_op = v.op; v_f3 = v.f3; v_f7 = v.f7; v_z = v.z;
        for (int i = 0; i < v.cyc; i++) begin
            cyc(v.fw, v.dw, s);
            if (s.mem_req && !s.adr_src) fetch_n++;
            if (s.ir_write) ir_n++;
            if (s.pc_write) pcw_n++;
            if (s.reg_write) begin
                regw_n++;
                if (s.result_src != v.rs_wb) bad_wb++;
            end
            if (s.mem_write && s.mem_req) memw_n++;
            if (s.illegal) ill_n++;
            if (s.imm != v.imm) bad_imm++;
            if (i == 0)
                chk({v.name, " fetch_sel"},
                    {30'd0, s.a, s.b, s.result_src}, {30'd0, 6'b00_10_10});
            if (i == v.fw + 1)
                chk({v.name, " decode_sel"},
                    {s.mem_req, s.a, s.b, s.alu}, {1'b0, 2'b01, 2'b01, 3'b000});
            if (i == v.fw + 2)
                chk({v.name, " exec_sel"},
                    {s.a, s.b, s.alu}, {v.a3, v.b3, v.alu3});
        end
        chk({v.name, " fetch_cycles"}, fetch_n, v.fw + 1);
        chk({v.name, " ir_write"}, ir_n, 1);
        chk({v.name, " pc_write"}, pcw_n, v.pcw);
        chk({v.name, " reg_write"}, regw_n, v.regw);
        chk({v.name, " mem_write"}, memw_n, v.memw);
        chk({v.name, " illegal"}, ill_n, v.ill);
        chk({v.name, " imm_src"}, bad_imm, 0);
        chk({v.name, " wb_src"}, bad_wb, 0);
        if (v.ill == 0) exp_retired++;
        @(posedge clk);
        #1;
        chk({v.name, " back_to_fetch"}, {adr_src, mem_req}, 2'b01);
        chk({v.name, " retired"}, retired, exp_retired);
        chk({v.name, " retired_wrap"}, w_retired, exp_retired % 4);
    endtask

    initial begin
        snap_t s;
        vec_t  v;
        logic [6:0] ops[7];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b0110111};

        tbl[0]  = mk("lw",   7'b0000011, 3'b010, 0, 0, 5, 1, 1, 0, 0,
                     2'b10, 2'b01, 2'b01, 2'b00, 3'b000);
        tbl[1]  = mk("sw",   7'b0100011, 3'b010, 0, 0, 4, 1, 0, 1, 0,
                     2'b10, 2'b01, 2'b00, 2'b01, 3'b000);
        tbl[2]  = mk("add",  7'b0110011, 3'b000, 0, 0, 4, 1, 1, 0, 0,
                     2'b10, 2'b00, 2'b00, 2'b00, 3'b000);
        tbl[3]  = mk("sub",  7'b0110011, 3'b000, 1, 0, 4, 1, 1, 0, 0,
                     2'b10, 2'b00, 2'b00, 2'b00, 3'b001);
        tbl[4]  = mk("addi", 7'b0010011, 3'b000, 1, 0, 4, 1, 1, 0, 0,
                     2'b10, 2'b01, 2'b00, 2'b00, 3'b000);
        tbl[5]  = mk("slt",  7'b0110011, 3'b010, 0, 0, 4, 1, 1, 0, 0,
                     2'b10, 2'b00, 2'b00, 2'b00, 3'b101);
        tbl[6]  = mk("or",   7'b0110011, 3'b110, 0, 0, 4, 1, 1, 0, 0,
                     2'b10, 2'b00, 2'b00, 2'b00, 3'b011);
        tbl[7]  = mk("andi", 7'b0010011, 3'b111, 0, 0, 4, 1, 1, 0, 0,
                     2'b10, 2'b01, 2'b00, 2'b00, 3'b010);
        tbl[8]  = mk("xor",  7'b0110011, 3'b100, 1, 0, 4, 1, 1, 0, 0,
                     2'b10, 2'b00, 2'b00, 2'b00, 3'b000);
        tbl[9]  = mk("beq_t", 7'b1100011, 3'b000, 0, 1, 3, 2, 0, 0, 0,
                     2'b10, 2'b00, 2'b00, 2'b10, 3'b001);
        tbl[10] = mk("beq_n", 7'b1100011, 3'b000, 0, 0, 3, 1, 0, 0, 0,
                     2'b10, 2'b00, 2'b00, 2'b10, 3'b001);
        tbl[11] = mk("jal",  7'b1101111, 3'b000, 0, 0, 4, 2, 1, 0, 0,
                     2'b01, 2'b10, 2'b00, 2'b11, 3'b000);
        tbl[12] = mk("bad",  7'b1111111, 3'b000, 0, 0, 2, 1, 0, 0, 1,
                     2'b00, 2'b00, 2'b00, 2'b00, 3'b000);

        reset = 1'b1; op = 7'b1101111; funct3 = 3'b111; funct7b5 = 1'b1;
        zero = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             illegal, result_src, alu_src_a, alu_src_b, imm_src, alu_control},
            '0);
        chk("reset_retired", retired, 0);
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        chk("release_fetch", {mem_req, adr_src, alu_src_b, result_src},
            {1'b1, 1'b0, 2'b10, 2'b10});

        for (int i = 0; i < 13; i++) run_instr(tbl[i]);

        // lw with a 3-cycle miss on fetch and on the data read
        v = model(7'b0000011, 3'b010, 0, 0, 3, 3);
        v.name = "lw_miss";
        run_instr(v);

        // reset while MEMREAD is stalled on the cache
        v_op = 7'b0000011; v_f3 = 3'b010; v_f7 = 0; v_z = 0;
        repeat (4) cyc(0, 1000, s);
        chk("stall_in_memread", {s.mem_req, s.adr_src}, 2'b11);
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0;
        #1;
        chk("reset_drops_req", {mem_req, illegal}, 2'b00);
        @(negedge clk);
        reset = 1'b0; wait_cnt = 0; exp_retired = 0;
        #1;
        chk("after_reset_fetch", {adr_src, mem_req}, 2'b01);
        chk("after_reset_retired", retired, 0);

        for (int n = 0; n < 150; n++) begin
            v = model(ops[$urandom_range(0, 6)], 3'($urandom),
                      1'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            run_instr(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
